// File: rtl/tlb_unit.sv
// Fully associative joint TLB: CP0 tlbp/tlbr/tlbwi/tlbwr responder plus
// registered instruction and data address translation (4 KB pages).
module tlb_unit #(
  parameter int unsigned TLB_LINE_NUM = 32,
  parameter int unsigned IDX_W        = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  tlb_type,
  input  logic [31:0] entry_hi,
  input  logic [31:0] page_mask,
  input  logic [31:0] entry_lo0,
  input  logic [31:0] entry_lo1,
  input  logic [31:0] index,
  input  logic [31:0] random,
  output logic [31:0] index_out,
  output logic [31:0] entry_hi_out,
  output logic [31:0] page_mask_out,
  output logic [31:0] entry_lo0_out,
  output logic [31:0] entry_lo1_out,
  input  logic        inst_req,
  input  logic [31:0] inst_vaddr,
  output logic [31:0] inst_paddr,
  output logic        inst_rvalid,
  output logic        inst_refill,
  output logic        inst_invalid,
  output logic        inst_uncached,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [31:0] data_vaddr,
  output logic [31:0] data_paddr,
  output logic        data_rvalid,
  output logic        data_refill,
  output logic        data_invalid,
  output logic        data_modify,
  output logic        data_uncached
);

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [11:0] mask;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
  } lookup_t;

  typedef struct packed {
    logic [31:0] paddr;
    logic        refill;
    logic        invalid;
    logic        modify;
    logic        uncached;
  } xlate_t;

  tlb_entry_t       tlb_q [TLB_LINE_NUM];
  tlb_entry_t       new_entry;
  tlb_entry_t       rd_entry;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  lookup_t          probe;
  xlate_t           inst_x;
  xlate_t           data_x;
  logic             unused_ok;

  // Lowest matching index wins when several entries hit.
  function automatic lookup_t lookup(input logic [18:0] vpn2, input logic [7:0] asid);
    lookup_t r;
    r.hit = 1'b0;
    r.idx = '0;
    for (int i = int'(TLB_LINE_NUM) - 1; i >= 0; i--) begin
      if (tlb_q[i].vpn2 == vpn2 && (tlb_q[i].g || tlb_q[i].asid == asid)) begin
        r.hit = 1'b1;
        r.idx = IDX_W'(i);
      end
    end
    return r;
  endfunction

  function automatic xlate_t translate(input logic [31:0] va, input logic wr);
    xlate_t     r;
    lookup_t    l;
    tlb_entry_t e;
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
    r = '0;
    if (va[31:30] == 2'b10) begin
      r.paddr    = {3'b000, va[28:0]};
      r.uncached = va[29];
    end else begin
      l   = lookup(va[31:13], entry_hi[7:0]);
      e   = tlb_q[l.idx];
      pfn = va[12] ? e.pfn1 : e.pfn0;
      c   = va[12] ? e.c1   : e.c0;
      d   = va[12] ? e.d1   : e.d0;
      v   = va[12] ? e.v1   : e.v0;
      if (!l.hit)        r.refill  = 1'b1;
      else if (!v)       r.invalid = 1'b1;
      else if (wr && !d) r.modify  = 1'b1;
      else begin
        r.paddr    = {pfn, va[11:0]};
        r.uncached = (c == 3'd2);
      end
    end
    return r;
  endfunction

  // Entry image assembled from the current CP0 registers.
  always_comb begin
    new_entry      = '0;
    new_entry.vpn2 = entry_hi[31:13];
    new_entry.asid = entry_hi[7:0];
    new_entry.g    = entry_lo0[0] & entry_lo1[0];
    new_entry.mask = page_mask[24:13];
    new_entry.pfn0 = entry_lo0[25:6];
    new_entry.c0   = entry_lo0[5:3];
    new_entry.d0   = entry_lo0[2];
    new_entry.v0   = entry_lo0[1];
    new_entry.pfn1 = entry_lo1[25:6];
    new_entry.c1   = entry_lo1[5:3];
    new_entry.d1   = entry_lo1[2];
    new_entry.v1   = entry_lo1[1];
  end

  assign wr_en  = tlb_type[3] | tlb_type[2];
  assign wr_idx = tlb_type[3] ? random[IDX_W-1:0] : index[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(TLB_LINE_NUM); i++) tlb_q[i] <= '0;
    end else if (wr_en) begin
      tlb_q[wr_idx] <= new_entry;
    end
  end

  // tlbp / tlbr results are combinational so CP0 latches them on the same edge.
  assign probe     = lookup(entry_hi[31:13], entry_hi[7:0]);
  assign index_out = probe.hit ? 32'(probe.idx) : 32'h8000_0000;
  assign rd_entry  = tlb_q[index[IDX_W-1:0]];

  assign entry_hi_out  = {rd_entry.vpn2, 5'b0, rd_entry.asid};
  assign page_mask_out = {7'b0, rd_entry.mask, 13'b0};
  assign entry_lo0_out = {6'b0, rd_entry.pfn0, rd_entry.c0, rd_entry.d0, rd_entry.v0, rd_entry.g};
  assign entry_lo1_out = {6'b0, rd_entry.pfn1, rd_entry.c1, rd_entry.d1, rd_entry.v1, rd_entry.g};

  // Lookups see pre-write contents; a same-cycle write lands at the edge.
  assign inst_x = translate(inst_vaddr, 1'b0);
  assign data_x = translate(data_vaddr, data_wr);

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_rvalid   <= 1'b0;
      inst_paddr    <= '0;
      inst_refill   <= 1'b0;
      inst_invalid  <= 1'b0;
      inst_uncached <= 1'b0;
      data_rvalid   <= 1'b0;
      data_paddr    <= '0;
      data_refill   <= 1'b0;
      data_invalid  <= 1'b0;
      data_modify   <= 1'b0;
      data_uncached <= 1'b0;
    end else begin
      inst_rvalid <= inst_req;
      data_rvalid <= data_req;
      if (inst_req) begin
        inst_paddr    <= inst_x.paddr;
        inst_refill   <= inst_x.refill;
        inst_invalid  <= inst_x.invalid;
        inst_uncached <= inst_x.uncached;
      end
      if (data_req) begin
        data_paddr    <= data_x.paddr;
        data_refill   <= data_x.refill;
        data_invalid  <= data_x.invalid;
        data_modify   <= data_x.modify;
        data_uncached <= data_x.uncached;
      end
    end
  end

  assign unused_ok = ^{entry_hi[12:8], page_mask[31:25], page_mask[12:0],
                       entry_lo0[31:26], entry_lo1[31:26], index[31:IDX_W],
                       random[31:IDX_W], tlb_type[1:0]};

endmodule

// File: tb/tb_tlb_unit.sv
// Self-checking bench for tlb_unit: table-driven translations with a
// scoreboard queue per port, plus CP0 op and hazard sequences.
module tb_tlb_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  tlb_type;
  logic [31:0] entry_hi, page_mask, entry_lo0, entry_lo1, index, random;
  logic [31:0] index_out, entry_hi_out, page_mask_out, entry_lo0_out, entry_lo1_out;
  logic        inst_req;
  logic [31:0] inst_vaddr, inst_paddr;
  logic        inst_rvalid, inst_refill, inst_invalid, inst_uncached;
  logic        data_req, data_wr;
  logic [31:0] data_vaddr, data_paddr;
  logic        data_rvalid, data_refill, data_invalid, data_modify, data_uncached;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [31:0] paddr;
    logic        refill;
    logic        invalid;
    logic        modify;
    logic        uncached;
  } exp_t;

  typedef struct {
    logic        is_inst;
    logic [31:0] va;
    logic        wr;
    logic [7:0]  asid;
    exp_t        exp;
  } vec_t;

  exp_t dq[$];
  exp_t iq[$];

  always #5 clk = ~clk;

  tlb_unit dut (
    .clk(clk), .rst(rst), .tlb_type(tlb_type),
    .entry_hi(entry_hi), .page_mask(page_mask), .entry_lo0(entry_lo0),
    .entry_lo1(entry_lo1), .index(index), .random(random),
    .index_out(index_out), .entry_hi_out(entry_hi_out), .page_mask_out(page_mask_out),
    .entry_lo0_out(entry_lo0_out), .entry_lo1_out(entry_lo1_out),
    .inst_req(inst_req), .inst_vaddr(inst_vaddr), .inst_paddr(inst_paddr),
    .inst_rvalid(inst_rvalid), .inst_refill(inst_refill), .inst_invalid(inst_invalid),
    .inst_uncached(inst_uncached),
    .data_req(data_req), .data_wr(data_wr), .data_vaddr(data_vaddr),
    .data_paddr(data_paddr), .data_rvalid(data_rvalid), .data_refill(data_refill),
    .data_invalid(data_invalid), .data_modify(data_modify), .data_uncached(data_uncached)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Pop expected results for requests issued in the previous cycle.
  task automatic check_ports();
    exp_t e;
    if (dq.size() > 0) begin
      e = dq.pop_front();
      check("data_rvalid", 32'(data_rvalid), 32'd1);
      check("data_paddr", data_paddr, e.paddr);
      check("data_flags", {28'd0, data_refill, data_invalid, data_modify, data_uncached},
            {28'd0, e.refill, e.invalid, e.modify, e.uncached});
    end else begin
      check("data_rvalid_idle", 32'(data_rvalid), 32'd0);
    end
    if (iq.size() > 0) begin
      e = iq.pop_front();
      check("inst_rvalid", 32'(inst_rvalid), 32'd1);
      check("inst_paddr", inst_paddr, e.paddr);
      check("inst_flags", {29'd0, inst_refill, inst_invalid, inst_uncached},
            {29'd0, e.refill, e.invalid, e.uncached});
    end else begin
      check("inst_rvalid_idle", 32'(inst_rvalid), 32'd0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_ports();
  endtask

  task automatic tlb_write(input logic rnd, input logic [31:0] idx, input logic [31:0] hi,
                           input logic [31:0] pm, input logic [31:0] lo0, input logic [31:0] lo1);
    tlb_type  = rnd ? 4'b1000 : 4'b0100;
    index     = idx;
    random    = idx;
    entry_hi  = hi;
    page_mask = pm;
    entry_lo0 = lo0;
    entry_lo1 = lo1;
    step();
    tlb_type = 4'b0000;
  endtask

  function automatic exp_t ok(input logic [31:0] pa, input logic uc);
    exp_t e;
    e = '{paddr: pa, refill: 1'b0, invalid: 1'b0, modify: 1'b0, uncached: uc};
    return e;
  endfunction

  function automatic exp_t flag(input int which);
    exp_t e;
    e = '{paddr: 32'd0, refill: (which == 0), invalid: (which == 1),
          modify: (which == 2), uncached: 1'b0};
    return e;
  endfunction

  vec_t vecs[$];
  exp_t e;

  initial begin
    rst = 1'b1; tlb_type = '0; entry_hi = '0; page_mask = '0; entry_lo0 = '0;
    entry_lo1 = '0; index = '0; random = '0; inst_req = 1'b0; inst_vaddr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_vaddr = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_data_paddr", data_paddr, 32'd0);
    check("rst_data_rvalid", 32'(data_rvalid), 32'd0);
    check("rst_inst_rvalid", 32'(inst_rvalid), 32'd0);
    check("rst_tlbp_entry0", index_out, 32'd0);
    check("rst_tlbr_lo0", entry_lo0_out, 32'd0);

    // Populate entries used by the vector table.
    tlb_write(1'b0, 32'd3,  32'h0040_2005, 32'd0,         32'h0048_D15E, 32'd0);
    tlb_write(1'b1, 32'd17, 32'h0100_0007, 32'h0000_6000, 32'h0002_AA97, 32'h0002_EEDB);
    tlb_write(1'b0, 32'd5,  32'h0200_0000, 32'd0,         32'h0000_155C, 32'd0);
    tlb_write(1'b0, 32'd9,  32'h0300_0000, 32'd0,         32'h0000_265E, 32'd0);
    tlb_write(1'b0, 32'd2,  32'h0300_0000, 32'd0,         32'h0000_089E, 32'd0);

    // tlbp / tlbr are combinational in the asserting cycle.
    tlb_type = 4'b0001; entry_hi = 32'h0040_2005; #1;
    check("tlbp_hit3", index_out, 32'h0000_0003);
    entry_hi = 32'h0080_0005; #1;
    check("tlbp_miss", index_out, 32'h8000_0000);
    entry_hi = 32'h0300_0000; #1;
    check("tlbp_lowest", index_out, 32'h0000_0002);
    tlb_type = 4'b0010; index = 32'd17; #1;
    check("tlbr_hi", entry_hi_out, 32'h0100_0007);
    check("tlbr_pm", page_mask_out, 32'h0000_6000);
    check("tlbr_lo0", entry_lo0_out, 32'h0002_AA97);
    check("tlbr_lo1", entry_lo1_out, 32'h0002_EEDB);
    tlb_type = 4'b0000;

    vecs = '{
      '{1'b0, 32'h9FC0_0004, 1'b0, 8'd0, ok(32'h1FC0_0004, 1'b0)},
      '{1'b0, 32'hBFC0_0000, 1'b0, 8'd0, ok(32'h1FC0_0000, 1'b1)},
      '{1'b0, 32'h0040_2ABC, 1'b0, 8'd5, ok(32'h1234_5ABC, 1'b0)},
      '{1'b0, 32'h0040_2ABC, 1'b0, 8'd6, flag(0)},
      '{1'b0, 32'h0040_2ABC, 1'b1, 8'd5, ok(32'h1234_5ABC, 1'b0)},
      '{1'b0, 32'h0040_3ABC, 1'b0, 8'd5, flag(1)},
      '{1'b0, 32'h0100_1010, 1'b1, 8'd3, flag(2)},
      '{1'b0, 32'h0100_1010, 1'b0, 8'd3, ok(32'h00BB_B010, 1'b0)},
      '{1'b0, 32'h0100_0020, 1'b0, 8'd9, ok(32'h00AA_A020, 1'b1)},
      '{1'b0, 32'h0300_0123, 1'b0, 8'd0, ok(32'h0002_2123, 1'b0)},
      '{1'b0, 32'h0000_1000, 1'b0, 8'd0, flag(1)},
      '{1'b0, 32'h0000_1000, 1'b0, 8'd1, flag(0)},
      '{1'b0, 32'hC000_0000, 1'b0, 8'd0, flag(0)},
      '{1'b0, 32'h8000_0010, 1'b1, 8'd0, ok(32'h0000_0010, 1'b0)},
      '{1'b1, 32'h0200_0000, 1'b0, 8'd0, flag(1)},
      '{1'b1, 32'h0040_2ABC, 1'b0, 8'd5, ok(32'h1234_5ABC, 1'b0)},
      '{1'b1, 32'hA000_1234, 1'b0, 8'd0, ok(32'h0000_1234, 1'b1)}
    };

    // Back-to-back requests; each result is popped one cycle later.
    foreach (vecs[i]) begin
      entry_hi   = {24'd0, vecs[i].asid};
      inst_req   = vecs[i].is_inst;
      data_req   = !vecs[i].is_inst;
      inst_vaddr = vecs[i].va;
      data_vaddr = vecs[i].va;
      data_wr    = vecs[i].wr;
      if (vecs[i].is_inst) iq.push_back(vecs[i].exp);
      else dq.push_back(vecs[i].exp);
      step();
    end
    inst_req = 1'b0; data_req = 1'b0; data_wr = 1'b0;
    data_vaddr = 32'h0040_2ABC;
    step();
    check("data_hold_paddr", data_paddr, 32'h0000_0010);

    // Same-cycle tlbwi and translation of that VPN returns the old mapping.
    tlb_type = 4'b0100; index = 32'd3; entry_hi = 32'h0040_2005;
    entry_lo0 = 32'h0150_C85E; entry_lo1 = 32'd0; page_mask = 32'd0;
    data_req = 1'b1; data_vaddr = 32'h0040_2ABC;
    dq.push_back(ok(32'h1234_5ABC, 1'b0));
    step();
    tlb_type = 4'b0000;
    dq.push_back(ok(32'h5432_1ABC, 1'b0));
    step();
    data_req = 1'b0;
    step();

    // Reset while a request is in flight discards the result.
    data_req = 1'b1; rst = 1'b1;
    step();
    check("rst_mid_paddr", data_paddr, 32'd0);
    data_req = 1'b0; rst = 1'b0;
    step();
    if (dq.size() != 0 || iq.size() != 0) check("scoreboard_drained", 32'(dq.size() + iq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
